// File: rtl/gpio_bus_master_if.sv
// rtl/gpio_bus_master_if.sv - core request and byte-wide GPIO memory bus bundle
interface gpio_bus_master_if;
  // core side request/response
  logic        req;
  logic        we;
  logic        size;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  // memory side
  logic        mem_rw_select;
  logic [8:0]  mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    input  req, we, size, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_rw_select, mem_address, mem_wdata
  );

  modport slave (
    output req, we, size, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_rw_select, mem_address, mem_wdata
  );
endinterface

// File: rtl/gpio_bus_master.sv
// rtl/gpio_bus_master.sv - byte/halfword load-store sequencer for the GPIO memory bus
module gpio_bus_master #(
  parameter int RD_LAT = 0,
  parameter int RO_LO  = 503,
  parameter int RO_HI  = 505
) (
  input  logic               clk,
  input  logic               reset,
  gpio_bus_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        size_q, size_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic [8:0]  maddr_q, maddr_d;
  logic [7:0]  mwdata_q, mwdata_d;

  // 10-bit compare so addr+1 of a halfword never wraps into the window
  function automatic logic in_ro(input logic [9:0] a);
    return (a >= 10'(RO_LO)) && (a <= 10'(RO_HI));
  endfunction

  logic bad_req;
  logic last_cycle;

  // Accept-time policing and the "this access cycle completes now" condition
  always_comb begin
    bad_req = 1'b0;
    if (bus.size && (bus.addr == 9'd511)) bad_req = 1'b1;
    if (bus.we && (in_ro({1'b0, bus.addr}) ||
                   (bus.size && in_ro({1'b0, bus.addr} + 10'd1)))) bad_req = 1'b1;
    last_cycle = we_q || (wait_q == LAT);
  end

  // Next state; outputs are computed from the state being entered so they are registered
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    rw_d     = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wait_d  = 2'd0;
          if (bad_req) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ACC0;
            maddr_d = bus.addr;
            if (bus.we) begin
              rw_d     = 1'b1;
              mwdata_d = bus.wdata[7:0];
            end
          end
        end
      end
      ACC0: begin
        if (last_cycle) begin
          if (!we_q) begin
            rdata_d[7:0] = bus.mem_rdata;
            if (!size_q) rdata_d[15:8] = 8'h00;
          end
          wait_d = 2'd0;
          if (size_q) begin
            state_d = ACC1;
            maddr_d = addr_q + 9'd1;
            if (we_q) begin
              rw_d     = 1'b1;
              mwdata_d = wdata_q[15:8];
            end
          end else begin
            state_d = RESP;
            done_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ACC1: begin
        if (last_cycle) begin
          if (!we_q) rdata_d[15:8] = bus.mem_rdata;
          wait_d  = 2'd0;
          state_d = RESP;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 1'b0;
      addr_q   <= 9'd0;
      wdata_q  <= 16'd0;
      wait_q   <= 2'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 16'd0;
      rw_q     <= 1'b0;
      maddr_q  <= 9'd0;
      mwdata_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rw_q     <= rw_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.rdata         = rdata_q;
  assign bus.mem_rw_select = rw_q;
  assign bus.mem_address   = maddr_q;
  assign bus.mem_wdata     = mwdata_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// tb/tb_gpio_bus_master.sv - directed self-checking bench, RD_LAT=0 and RD_LAT=2 instances
module tb_gpio_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_clr;
  logic        req_i, we_i, size_i;
  logic [8:0]  addr_i;
  logic [15:0] wdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bus_master_if if0 ();
  gpio_bus_master_if if2 ();

  gpio_bus_master #(.RD_LAT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  gpio_bus_master #(.RD_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.req = req_i;   assign if2.req = req_i;
  assign if0.we = we_i;     assign if2.we = we_i;
  assign if0.size = size_i; assign if2.size = size_i;
  assign if0.addr = addr_i; assign if2.addr = addr_i;
  assign if0.wdata = wdata_i; assign if2.wdata = wdata_i;

  logic [7:0] mem0 [512];
  logic [7:0] mem2 [512];
  logic [8:0] apipe1, apipe2;

  // memory models: mem0 reads combinationally, mem2 returns data two cycles after the address
  assign if0.mem_rdata = mem0[if0.mem_address];
  assign if2.mem_rdata = mem2[apipe2];

  always @(posedge clk) begin
    apipe1 <= if2.mem_address;
    apipe2 <= apipe1;
    if (mem_clr) begin
      for (int k = 0; k < 512; k++) begin
        mem0[k] <= 8'h00;
        mem2[k] <= 8'h00;
      end
      mem0[504] <= 8'h81; mem0[505] <= 8'h3C;
      mem2[504] <= 8'h81; mem2[505] <= 8'h3C;
    end else begin
      if (if0.mem_rw_select) mem0[if0.mem_address] <= if0.mem_wdata;
      if (if2.mem_rw_select) mem2[if2.mem_address] <= if2.mem_wdata;
    end
  end

  logic        done_w [2];
  logic        err_w  [2];
  logic        rw_w   [2];
  logic        rdy_w  [2];
  logic [15:0] rd_w   [2];
  logic [8:0]  ad_w   [2];
  logic [7:0]  wd_w   [2];
  assign done_w[0] = if0.done;  assign done_w[1] = if2.done;
  assign err_w[0]  = if0.err;   assign err_w[1]  = if2.err;
  assign rw_w[0]   = if0.mem_rw_select; assign rw_w[1] = if2.mem_rw_select;
  assign rdy_w[0]  = if0.ready; assign rdy_w[1]  = if2.ready;
  assign rd_w[0]   = if0.rdata; assign rd_w[1]   = if2.rdata;
  assign ad_w[0]   = if0.mem_address; assign ad_w[1] = if2.mem_address;
  assign wd_w[0]   = if0.mem_wdata;   assign wd_w[1] = if2.mem_wdata;

  int          done_cyc [2];
  int          done_cnt [2];
  int          strobes  [2];
  logic        err_at   [2];
  logic [15:0] rd_at    [2];
  logic        rw_c     [2][16];
  logic [8:0]  ad_c     [2][16];
  logic [7:0]  wd_c     [2][16];
  logic        rdy_c    [2][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one request; records 14 cycles after the accept edge for both instances
  task automatic run_txn(input logic w, input logic s, input logic [8:0] a,
                         input logic [15:0] d, input logic poke);
    @(negedge clk);
    req_i = 1'b1; we_i = w; size_i = s; addr_i = a; wdata_i = d;
    for (int i = 0; i < 2; i++) begin
      done_cyc[i] = -1; done_cnt[i] = 0; strobes[i] = 0;
      err_at[i] = 1'b0; rd_at[i] = 16'hDEAD;
    end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) req_i = 1'b0;
      if (poke && c == 2) begin
        req_i = 1'b1; we_i = 1'b1; size_i = 1'b0; addr_i = 9'd0; wdata_i = 16'h00FF;
      end
      if (poke && c == 3) req_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
        rw_c[i][c] = rw_w[i]; ad_c[i][c] = ad_w[i];
        wd_c[i][c] = wd_w[i]; rdy_c[i][c] = rdy_w[i];
        if (rw_w[i]) strobes[i]++;
        if (done_w[i]) begin
          done_cnt[i]++;
          if (done_cyc[i] < 0) begin
            done_cyc[i] = c; err_at[i] = err_w[i]; rd_at[i] = rd_w[i];
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_i = 1'b0; we_i = 1'b0; size_i = 1'b0; addr_i = 9'd0; wdata_i = 16'd0;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    reset = 1'b0;

    // reset values
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(rdy_w[i]), 32'd1);
      check("rst_done",  32'(done_w[i]), 32'd0);
      check("rst_err",   32'(err_w[i]), 32'd0);
      check("rst_rdata", 32'(rd_w[i]), 32'd0);
      check("rst_rw",    32'(rw_w[i]), 32'd0);
      check("rst_addr",  32'(ad_w[i]), 32'd0);
      check("rst_wdata", 32'(wd_w[i]), 32'd0);
    end

    // byte store 508 <- 0x07
    run_txn(1'b1, 1'b0, 9'd508, 16'h0007, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("bs_ready_c1", 32'(rdy_c[i][1]), 32'd0);
      check("bs_rw_c1",    32'(rw_c[i][1]), 32'd1);
      check("bs_addr_c1",  32'(ad_c[i][1]), 32'd508);
      check("bs_wd_c1",    32'(wd_c[i][1]), 32'h07);
      check("bs_done_cyc", 32'(done_cyc[i]), 32'd2);
      check("bs_err",      32'(err_at[i]), 32'd0);
      check("bs_strobes",  32'(strobes[i]), 32'd1);
      check("bs_ready_c3", 32'(rdy_c[i][3]), 32'd1);
    end
    check("bs_mem0", 32'(mem0[508]), 32'h07);
    check("bs_mem2", 32'(mem2[508]), 32'h07);

    // halfword store 506 <- 0xA55A
    run_txn(1'b1, 1'b1, 9'd506, 16'hA55A, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("hs_addr_c1", 32'(ad_c[i][1]), 32'd506);
      check("hs_wd_c1",   32'(wd_c[i][1]), 32'h5A);
      check("hs_addr_c2", 32'(ad_c[i][2]), 32'd507);
      check("hs_wd_c2",   32'(wd_c[i][2]), 32'hA5);
      check("hs_rw_c2",   32'(rw_c[i][2]), 32'd1);
      check("hs_done_cyc", 32'(done_cyc[i]), 32'd3);
      check("hs_strobes", 32'(strobes[i]), 32'd2);
    end
    check("hs_mem0_507", 32'(mem0[507]), 32'hA5);
    check("hs_mem2_506", 32'(mem2[506]), 32'h5A);

    // halfword load 506: L=0 done at 3, L=2 done at 7
    run_txn(1'b0, 1'b1, 9'd506, 16'h0000, 1'b0);
    check("hl_done_cyc_l0", 32'(done_cyc[0]), 32'd3);
    check("hl_done_cyc_l2", 32'(done_cyc[1]), 32'd7);
    for (int i = 0; i < 2; i++) begin
      check("hl_rdata",   32'(rd_at[i]), 32'hA55A);
      check("hl_err",     32'(err_at[i]), 32'd0);
      check("hl_strobes", 32'(strobes[i]), 32'd0);
    end

    // byte load 504 (switch low byte 0x81); L=2 holds the address three cycles
    run_txn(1'b0, 1'b0, 9'd504, 16'h0000, 1'b0);
    check("bl_done_cyc_l0", 32'(done_cyc[0]), 32'd2);
    check("bl_done_cyc_l2", 32'(done_cyc[1]), 32'd4);
    check("bl_addr_c1", 32'(ad_c[1][1]), 32'd504);
    check("bl_addr_c3", 32'(ad_c[1][3]), 32'd504);
    check("bl_rw_c2",   32'(rw_c[1][2]), 32'd0);
    for (int i = 0; i < 2; i++) check("bl_rdata", 32'(rd_at[i]), 32'h0081);

    // halfword store 502 touches read-only 503
    run_txn(1'b1, 1'b1, 9'd502, 16'h1234, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("ro_hs_done_cyc", 32'(done_cyc[i]), 32'd1);
      check("ro_hs_err",      32'(err_at[i]), 32'd1);
      check("ro_hs_strobes",  32'(strobes[i]), 32'd0);
      check("ro_hs_rdata",    32'(rd_at[i]), 32'h0081);
      check("ro_hs_err_c2",   32'(err_w[i]), 32'd0);
    end
    check("ro_hs_mem502", 32'(mem0[502]), 32'h00);

    // byte store to 505 (switch high byte)
    run_txn(1'b1, 1'b0, 9'd505, 16'h00FF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("ro_bs_err",     32'(err_at[i]), 32'd1);
      check("ro_bs_strobes", 32'(strobes[i]), 32'd0);
    end
    check("ro_bs_mem505", 32'(mem2[505]), 32'h3C);

    // halfword load at 511 would wrap
    run_txn(1'b0, 1'b1, 9'd511, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("wrap_done_cyc", 32'(done_cyc[i]), 32'd1);
      check("wrap_err",      32'(err_at[i]), 32'd1);
      check("wrap_rdata",    32'(rd_at[i]), 32'h0081);
    end

    // a second req during an in-flight halfword load is dropped
    run_txn(1'b0, 1'b1, 9'd506, 16'h0000, 1'b1);
    check("poke_done_cyc_l0", 32'(done_cyc[0]), 32'd3);
    check("poke_done_cyc_l2", 32'(done_cyc[1]), 32'd7);
    for (int i = 0; i < 2; i++) begin
      check("poke_done_cnt", 32'(done_cnt[i]), 32'd1);
      check("poke_strobes",  32'(strobes[i]), 32'd0);
      check("poke_rdata",    32'(rd_at[i]), 32'hA55A);
    end
    check("poke_mem0_0", 32'(mem0[0]), 32'h00);

    // reset during cycle 1 of a halfword store
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 1'b1; addr_i = 9'd300; wdata_i = 16'hBEEF;
    @(negedge clk);
    req_i = 1'b0;
    check("rst_mid_rw_c1", 32'(rw_w[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_mid_rw",    32'(rw_w[i]), 32'd0);
      check("rst_mid_ready", 32'(rdy_w[i]), 32'd1);
      check("rst_mid_rdata", 32'(rd_w[i]), 32'd0);
      done_cnt[i] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (done_w[i]) done_cnt[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      check("rst_mid_no_done", 32'(done_cnt[i]), 32'd0);
      check("rst_mid_ready2",  32'(rdy_w[i]), 32'd1);
    end
    check("rst_mid_mem0_300", 32'(mem0[300]), 32'hEF);
    check("rst_mid_mem0_301", 32'(mem0[301]), 32'h00);
    check("rst_mid_mem2_300", 32'(mem2[300]), 32'hEF);
    check("rst_mid_mem2_301", 32'(mem2[301]), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
